// File: rtl/xbus_pkg.sv
// Shared xbus link definitions: word tags, control-word bit positions,
// target FSM states and a control-word builder.
package xbus_pkg;

    // Word tags carried in bits [35:32]
    localparam logic [3:0] XB_NOP  = 4'd0;
    localparam logic [3:0] XB_ADR  = 4'd1;
    localparam logic [3:0] XB_CTRL = 4'd3;
    localparam logic [3:0] XB_D0   = 4'd4;
    localparam logic [3:0] XB_D1   = 4'd5;
    localparam logic [3:0] XB_D2   = 4'd6;
    localparam logic [3:0] XB_D3   = 4'd7;

    // Control payload bit positions
    localparam int unsigned CB_WE     = 31;
    localparam int unsigned CB_TRIG   = 30;
    localparam int unsigned CB_SYNC   = 29;
    localparam int unsigned CB_ERR    = 28;
    localparam int unsigned CB_MST_HI = 27;
    localparam int unsigned CB_MST_LO = 22;
    localparam int unsigned CB_DEV_HI = 21;
    localparam int unsigned CB_DEV_LO = 16;
    localparam int unsigned CB_SEL_HI = 15;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CYCLE = 2'd1,
        RESP  = 2'd2,
        DONE  = 2'd3
    } xb_tstate_t;

    // Assemble a tagged control word from its fields
    function automatic logic [35:0] xb_ctrl_word(
        input logic        we,
        input logic        trig,
        input logic        sync,
        input logic        err,
        input logic [5:0]  master,
        input logic [5:0]  dev,
        input logic [15:0] sel
    );
        logic [35:0] w;
        w                        = 36'h0;
        w[35:32]                 = XB_CTRL;
        w[CB_WE]                 = we;
        w[CB_TRIG]               = trig;
        w[CB_SYNC]               = sync;
        w[CB_ERR]                = err;
        w[CB_MST_HI:CB_MST_LO]   = master;
        w[CB_DEV_HI:CB_DEV_LO]   = dev;
        w[CB_SEL_HI:0]           = sel;
        return w;
    endfunction

endpackage

// File: rtl/xbus_word_decode.sv
// Combinational split of a received xbus word into tag class and control
// fields, plus the device-select compare against this target's number.
module xbus_word_decode #(
    parameter logic [5:0] kDevNum = 6'd1
) (
    input  logic [35:0] xbd,
    output logic [31:0] payload,
    output logic        is_adr,
    output logic        is_ctrl,
    output logic        is_data,
    output logic [1:0]  lane,
    output logic        we,
    output logic        trig,
    output logic        sync,
    output logic [5:0]  master,
    output logic [15:0] sel,
    output logic        dev_match
);
    import xbus_pkg::*;

    logic [3:0] tag_s;

    assign tag_s     = xbd[35:32];
    assign payload   = xbd[31:0];
    assign is_adr    = (tag_s == XB_ADR);
    assign is_ctrl   = (tag_s == XB_CTRL);
    assign is_data   = (tag_s == XB_D0) || (tag_s == XB_D1) ||
                       (tag_s == XB_D2) || (tag_s == XB_D3);
    assign lane      = tag_s[1:0];
    assign we        = xbd[CB_WE];
    assign trig      = xbd[CB_TRIG];
    assign sync      = xbd[CB_SYNC];
    assign master    = xbd[CB_MST_HI:CB_MST_LO];
    assign sel       = xbd[CB_SEL_HI:0];
    assign dev_match = (xbd[CB_DEV_HI:CB_DEV_LO] == kDevNum);

endmodule

// File: rtl/xbus_target.sv
// Device-side xbus endpoint: collects address/data/control words from the
// bridge, runs one 128-bit local bus-master cycle, then returns read lanes
// and a completion control word on the transmit link.
module xbus_target #(
    parameter logic [5:0] kDevNum  = 6'd1,
    parameter logic [8:0] kTimeout = 9'd256
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic [35:0]  xbd_i,
    input  logic         xb_de_i,
    input  logic         tx_de_i,
    output logic [35:0]  xbd_o,
    output logic         cyc_o,
    output logic         stb_o,
    output logic         we_o,
    output logic [15:0]  sel_o,
    output logic [31:0]  adr_o,
    output logic [127:0] dat_o,
    input  logic         ack_i,
    input  logic         err_i,
    input  logic [127:0] dat_i,
    output logic         sel_flag_o,
    output logic         ovr_o
);
    import xbus_pkg::*;

    localparam logic [8:0] TMO_LAST = kTimeout - 9'd1;

    xb_tstate_t state_r, state_next_s;

    logic [35:0]  xbd_r, xbd_next_s;
    logic         cyc_r, we_r, err_r;
    logic [15:0]  sel_r;
    logic [5:0]   mst_r;
    logic [31:0]  adr_r;
    logic [127:0] dat_r, rbuf_r;
    logic         sel_flag_r, ovr_r;
    logic         sync_r;
    logic [5:0]   sync_mst_r;
    logic [8:0]   tmo_cnt_r;
    logic [2:0]   lane_idx_r;

    logic [31:0]  payload_s;
    logic         is_adr_s, is_ctrl_s, is_data_s;
    logic [1:0]   lane_s;
    logic         we_s, trig_s, sync_s, dev_match_s;
    logic [5:0]   master_s;
    logic [15:0]  sel_s;

    logic         idle_s, hit_ctrl_s, trig_go_s, ld_adr_s, ld_dat_s, drop_s;
    logic         bus_end_s, bus_ok_s;
    logic [3:0]   lane_hit_s;
    logic [1:0]   cur_lane_s;
    logic         found_s, more_s;

    xbus_word_decode #(.kDevNum(kDevNum)) u_decode (
        .xbd       (xbd_i),
        .payload   (payload_s),
        .is_adr    (is_adr_s),
        .is_ctrl   (is_ctrl_s),
        .is_data   (is_data_s),
        .lane      (lane_s),
        .we        (we_s),
        .trig      (trig_s),
        .sync      (sync_s),
        .master    (master_s),
        .sel       (sel_s),
        .dev_match (dev_match_s)
    );

    // A control word carries its own device select, so it is judged by its
    // own compare; address/data words rely on the current selection.
    assign idle_s     = (state_r == IDLE);
    assign hit_ctrl_s = xb_de_i && is_ctrl_s && dev_match_s;
    assign trig_go_s  = hit_ctrl_s && trig_s && idle_s;
    assign ld_adr_s   = xb_de_i && sel_flag_r && idle_s && is_adr_s;
    assign ld_dat_s   = xb_de_i && sel_flag_r && idle_s && is_data_s;
    assign drop_s     = !idle_s &&
                        ((xb_de_i && sel_flag_r && (is_adr_s || is_data_s)) ||
                         (hit_ctrl_s && trig_s));
    assign bus_ok_s   = ack_i && !err_i;
    assign bus_end_s  = (state_r == CYCLE) &&
                        (ack_i || err_i || (tmo_cnt_r == TMO_LAST));

    assign lane_hit_s[0] = |sel_r[3:0];
    assign lane_hit_s[1] = |sel_r[7:4];
    assign lane_hit_s[2] = |sel_r[11:8];
    assign lane_hit_s[3] = |sel_r[15:12];

    // Find the next enabled read lane at or after lane_idx_r and whether any follow it
    always_comb begin
        cur_lane_s = 2'd0;
        found_s    = 1'b0;
        more_s     = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (lane_hit_s[i] && (3'(i) >= lane_idx_r)) begin
                if (found_s) begin
                    more_s = 1'b1;
                end else begin
                    found_s    = 1'b1;
                    cur_lane_s = 2'(i);
                end
            end else begin
                more_s = more_s;
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next state and the word to transmit on the next tx slot.
    // A read with no byte lanes enabled has nothing to return, so it goes
    // straight to DONE instead of parking in RESP.
    always_comb begin
        state_next_s = state_r;
        xbd_next_s   = xbd_r;
        case (state_r)
            IDLE: begin
                if (sync_r) begin
                    xbd_next_s = xb_ctrl_word(1'b0, 1'b0, 1'b1, 1'b0, sync_mst_r,
                                              kDevNum, 16'h0000);
                end else begin
                    xbd_next_s = {XB_NOP, 32'h0000_0000};
                end
                if (trig_go_s) begin
                    state_next_s = CYCLE;
                end else begin
                    state_next_s = IDLE;
                end
            end
            CYCLE: begin
                if (bus_end_s) begin
                    if (!we_r && (|sel_r)) begin
                        state_next_s = RESP;
                    end else begin
                        state_next_s = DONE;
                    end
                end else begin
                    state_next_s = CYCLE;
                end
            end
            RESP: begin
                xbd_next_s = {XB_D0 + {2'b00, cur_lane_s},
                              rbuf_r[{cur_lane_s, 5'd0} +: 32]};
                if (tx_de_i && !more_s) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = RESP;
                end
            end
            DONE: begin
                xbd_next_s = xb_ctrl_word(we_r, 1'b1, 1'b0, err_r, mst_r, kDevNum, sel_r);
                if (tx_de_i) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = DONE;
                end
            end
            default: begin
                state_next_s = IDLE;
                xbd_next_s   = {XB_NOP, 32'h0000_0000};
            end
        endcase
    end

    // Receive side: selection, address/data staging, overrun flag and sync echo request
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sel_flag_r <= 1'b0;
            adr_r      <= 32'h0000_0000;
            dat_r      <= 128'h0;
            ovr_r      <= 1'b0;
            sync_r     <= 1'b0;
            sync_mst_r <= 6'd0;
        end else begin
            if (xb_de_i && is_ctrl_s) begin
                sel_flag_r <= dev_match_s;
            end
            if (ld_adr_s) begin
                adr_r <= payload_s;
            end
            if (ld_dat_s) begin
                dat_r[{lane_s, 5'd0} +: 32] <= payload_s;
            end
            if (drop_s) begin
                ovr_r <= 1'b1;
            end
            if (hit_ctrl_s) begin
                if (sync_s && !trig_s) begin
                    sync_r     <= 1'b1;
                    sync_mst_r <= master_s;
                end else if (!sync_s) begin
                    sync_r <= 1'b0;
                end
            end
        end
    end

    // Local-bus master cycle: latch the command on trigger, end on ack, err or timeout
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cyc_r     <= 1'b0;
            we_r      <= 1'b0;
            sel_r     <= 16'h0000;
            mst_r     <= 6'd0;
            err_r     <= 1'b0;
            tmo_cnt_r <= 9'd0;
            rbuf_r    <= 128'h0;
        end else if (trig_go_s) begin
            cyc_r     <= 1'b1;
            we_r      <= we_s;
            sel_r     <= sel_s;
            mst_r     <= master_s;
            err_r     <= 1'b0;
            tmo_cnt_r <= 9'd0;
        end else if (state_r == CYCLE) begin
            if (bus_end_s) begin
                cyc_r <= 1'b0;
                if (bus_ok_s) begin
                    rbuf_r <= dat_i;
                    err_r  <= 1'b0;
                end else begin
                    rbuf_r <= 128'h0;
                    err_r  <= 1'b1;
                end
            end else if (tmo_cnt_r != 9'h1FF) begin
                tmo_cnt_r <= tmo_cnt_r + 9'd1;
            end
        end
    end

    // Transmit side: update the outgoing word and lane pointer only on tx slots
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            xbd_r      <= 36'h0;
            lane_idx_r <= 3'd0;
        end else begin
            if (tx_de_i) begin
                xbd_r <= xbd_next_s;
            end
            if (trig_go_s) begin
                lane_idx_r <= 3'd0;
            end else if ((state_r == RESP) && tx_de_i) begin
                lane_idx_r <= {1'b0, cur_lane_s} + 3'd1;
            end
        end
    end

    assign xbd_o      = xbd_r;
    assign cyc_o      = cyc_r;
    assign stb_o      = cyc_r;
    assign we_o       = we_r;
    assign sel_o      = sel_r;
    assign adr_o      = adr_r;
    assign dat_o      = dat_r;
    assign sel_flag_o = sel_flag_r;
    assign ovr_o      = ovr_r;

endmodule

// File: tb/tb_xbus_target.sv
// Self-checking bench for xbus_target: selection vector table, directed
// corner sequences and randomized transactions against a transaction-level model.
module tb_xbus_target;

    logic         clk_i = 1'b0;
    logic         rst_ni;
    logic [35:0]  xbd_i;
    logic         xb_de_i;
    logic         tx_de_i;
    logic [35:0]  xbd_o;
    logic         cyc_o, stb_o, we_o;
    logic [15:0]  sel_o;
    logic [31:0]  adr_o;
    logic [127:0] dat_o;
    logic         ack_i, err_i;
    logic [127:0] dat_i;
    logic         sel_flag_o, ovr_o;

    xbus_target #(.kDevNum(6'd1), .kTimeout(9'd256)) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .xbd_i      (xbd_i),
        .xb_de_i    (xb_de_i),
        .tx_de_i    (tx_de_i),
        .xbd_o      (xbd_o),
        .cyc_o      (cyc_o),
        .stb_o      (stb_o),
        .we_o       (we_o),
        .sel_o      (sel_o),
        .adr_o      (adr_o),
        .dat_o      (dat_o),
        .ack_i      (ack_i),
        .err_i      (err_i),
        .dat_i      (dat_i),
        .sel_flag_o (sel_flag_o),
        .ovr_o      (ovr_o)
    );

    always #5 clk_i = ~clk_i;

    int n_chk  = 0;
    int n_pass = 0;

    // transmit-slot control: 0 always on, 1 random, 2 manual
    int   tx_mode = 0;
    logic tx_man  = 1'b0;

    // reference model state
    logic [31:0]  model_adr;
    logic [31:0]  model_dat [4];
    logic         exp_we;
    logic [15:0]  exp_sel;
    logic [5:0]   exp_mst;
    logic [35:0]  exp_q [$];
    logic [35:0]  got_q [$];

    typedef struct {
        logic [3:0]  tag;
        logic [31:0] pay;
        logic        de;
        logic        exp_flag;
        logic [31:0] exp_adr;
    } vec_t;
    vec_t vecs [10];

    // Drive transmit slots on the falling edge
    initial begin
        tx_de_i = 1'b1;
        forever begin
            @(negedge clk_i);
            case (tx_mode)
                0:       tx_de_i = 1'b1;
                1:       tx_de_i = ($urandom_range(3, 0) != 0);
                default: tx_de_i = tx_man;
            endcase
        end
    end

    // Collect every non-NOP word the target transmits
    always @(xbd_o) begin
        if (xbd_o != 36'h0) got_q.push_back(xbd_o);
    end

    function automatic logic [31:0] ctrl_pay(input logic we, input logic trig, input logic sync,
                                             input logic err, input logic [5:0] mst,
                                             input logic [5:0] dev, input logic [15:0] sel);
        return {we, trig, sync, err, mst, dev, sel};
    endfunction

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got %h expected %h", name, got, exp);
        else n_pass++;
    endtask

    task automatic send(input logic [3:0] tag, input logic [31:0] pay);
        xbd_i   = {tag, pay};
        xb_de_i = 1'b1;
        @(posedge clk_i); #1;
        xb_de_i = 1'b0;
        xbd_i   = 36'h0;
    endtask

    task automatic load_adr(input logic [31:0] a);
        send(4'h1, a);
        model_adr = a;
    endtask

    task automatic load_dat(input int n, input logic [31:0] d);
        send(4'(4 + n), d);
        model_dat[n] = d;
    endtask

    task automatic start_txn(input logic we, input logic [15:0] sel, input logic [5:0] mst);
        exp_we  = we;
        exp_sel = sel;
        exp_mst = mst;
        got_q.delete();
        send(4'h3, ctrl_pay(we, 1'b1, 1'b0, 1'b0, mst, 6'd1, sel));
        chk("cyc rise", 128'(cyc_o), 128'(1'b1));
        chk("stb rise", 128'(stb_o), 128'(1'b1));
        chk("we_o", 128'(we_o), 128'(we));
        chk("sel_o", 128'(sel_o), 128'(sel));
        chk("adr_o", 128'(adr_o), 128'(model_adr));
        chk("dat_o", dat_o, {model_dat[3], model_dat[2], model_dat[1], model_dat[0]});
    endtask

    // term: 0 ack, 1 err, 2 no response (timeout)
    task automatic finish_txn(input int term, input int delay, input logic [127:0] rd);
        logic bad;
        int   cnt;
        exp_q.delete();
        if (term == 2) begin
            cnt = 1;
            for (int i = 0; i < 300; i++) begin
                @(posedge clk_i); #1;
                if (cyc_o) cnt++;
                else break;
            end
            chk("timeout cycles", 128'(cnt), 128'(256));
        end else begin
            for (int i = 0; i < delay; i++) begin
                @(posedge clk_i); #1;
                chk("cyc held", 128'(cyc_o), 128'(1'b1));
            end
            dat_i = rd;
            if (term == 0) ack_i = 1'b1;
            else err_i = 1'b1;
            @(posedge clk_i); #1;
            ack_i = 1'b0;
            err_i = 1'b0;
            dat_i = {4{$urandom}};
            chk("cyc fall", 128'(cyc_o), 128'(1'b0));
        end
        bad = (term != 0);
        if (!exp_we) begin
            for (int n = 0; n < 4; n++)
                if (exp_sel[4*n +: 4] != 4'h0)
                    exp_q.push_back({4'(4 + n), bad ? 32'h0 : rd[32*n +: 32]});
        end
        exp_q.push_back({4'h3, ctrl_pay(exp_we, 1'b1, 1'b0, bad, exp_mst, 6'd1, exp_sel)});
    endtask

    task automatic expect_words();
        int guard;
        guard = 0;
        while ((got_q.size() < exp_q.size()) && (guard < 1000)) begin
            @(posedge clk_i); #1;
            guard++;
        end
        repeat (2) @(posedge clk_i);
        #1;
        chk("word count", 128'(got_q.size()), 128'(exp_q.size()));
        for (int i = 0; (i < exp_q.size()) && (i < got_q.size()); i++)
            chk($sformatf("word %0d", i), 128'(got_q[i]), 128'(exp_q[i]));
        guard = 0;
        while ((xbd_o != 36'h0) && (guard < 100)) begin
            @(posedge clk_i); #1;
            guard++;
        end
        chk("nop after done", 128'(xbd_o), 128'(0));
    endtask

    task automatic chk_reset_outputs(input string tagname);
        chk({tagname, " xbd_o"}, 128'(xbd_o), 128'(0));
        chk({tagname, " cyc_o"}, 128'(cyc_o), 128'(0));
        chk({tagname, " stb_o"}, 128'(stb_o), 128'(0));
        chk({tagname, " we_o"}, 128'(we_o), 128'(0));
        chk({tagname, " sel_o"}, 128'(sel_o), 128'(0));
        chk({tagname, " adr_o"}, 128'(adr_o), 128'(0));
        chk({tagname, " dat_o"}, dat_o, 128'(0));
        chk({tagname, " sel_flag_o"}, 128'(sel_flag_o), 128'(0));
        chk({tagname, " ovr_o"}, 128'(ovr_o), 128'(0));
    endtask

    initial begin
        logic [127:0] rd;
        logic [15:0]  sel;
        logic [31:0]  a;
        logic         we;
        logic [35:0]  sync_word;

        rst_ni  = 1'b0;
        xbd_i   = 36'h0;
        xb_de_i = 1'b0;
        ack_i   = 1'b0;
        err_i   = 1'b0;
        dat_i   = 128'h0;
        model_adr = 32'h0;
        for (int n = 0; n < 4; n++) model_dat[n] = 32'h0;

        repeat (3) @(posedge clk_i);
        #1;
        chk_reset_outputs("reset");
        rst_ni = 1'b1;
        @(posedge clk_i); #1;

        // selection / address-load vectors applied from IDLE
        vecs[0] = '{4'h1, 32'h1234_5678, 1'b1, 1'b0, 32'h0};
        vecs[1] = '{4'h3, ctrl_pay(1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 6'd2, 16'h0), 1'b1, 1'b0, 32'h0};
        vecs[2] = '{4'h1, 32'h5555_0000, 1'b1, 1'b0, 32'h0};
        vecs[3] = '{4'h3, ctrl_pay(1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 6'd1, 16'h0), 1'b1, 1'b1, 32'h0};
        vecs[4] = '{4'h1, 32'hFB00_1000, 1'b0, 1'b1, 32'h0};
        vecs[5] = '{4'h1, 32'hFB00_1000, 1'b1, 1'b1, 32'hFB00_1000};
        vecs[6] = '{4'h3, ctrl_pay(1'b1, 1'b1, 1'b0, 1'b0, 6'd0, 6'd2, 16'hFFFF), 1'b1, 1'b0, 32'hFB00_1000};
        vecs[7] = '{4'h1, 32'hAAAA_0000, 1'b1, 1'b0, 32'hFB00_1000};
        vecs[8] = '{4'h3, ctrl_pay(1'b1, 1'b1, 1'b0, 1'b0, 6'd0, 6'd1, 16'hFFFF), 1'b0, 1'b0, 32'hFB00_1000};
        vecs[9] = '{4'h3, ctrl_pay(1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 6'd1, 16'h0), 1'b1, 1'b1, 32'hFB00_1000};
        for (int i = 0; i < 10; i++) begin
            xbd_i   = {vecs[i].tag, vecs[i].pay};
            xb_de_i = vecs[i].de;
            @(posedge clk_i); #1;
            xb_de_i = 1'b0;
            xbd_i   = 36'h0;
            chk($sformatf("vec%0d sel_flag", i), 128'(sel_flag_o), 128'(vecs[i].exp_flag));
            chk($sformatf("vec%0d adr", i), 128'(adr_o), 128'(vecs[i].exp_adr));
            chk($sformatf("vec%0d cyc", i), 128'(cyc_o), 128'(0));
            chk($sformatf("vec%0d xbd nop", i), 128'(xbd_o), 128'(0));
        end
        model_adr = 32'hFB00_1000;

        // write cycle
        load_adr(32'hFB00_1000);
        load_dat(0, 32'hDEAD_BEEF);
        start_txn(1'b1, 16'h000F, 6'd3);
        finish_txn(0, 0, 128'h0);
        expect_words();

        // read with sparse byte lanes
        start_txn(1'b0, 16'hF0F0, 6'h2A);
        finish_txn(0, 2, {{4{8'h44}}, {4{8'h33}}, {4{8'h22}}, {4{8'h11}}});
        expect_words();

        // no ack: timeout aborts with error
        start_txn(1'b1, 16'h00FF, 6'd9);
        finish_txn(2, 0, 128'h0);
        expect_words();

        // read terminated by err returns zeroed lanes
        start_txn(1'b0, 16'h0F00, 6'd4);
        finish_txn(1, 1, {4{32'hCAFE_F00D}});
        expect_words();

        // sync echo on and off
        send(4'h3, ctrl_pay(1'b0, 1'b0, 1'b1, 1'b0, 6'd5, 6'd1, 16'h0));
        repeat (2) @(posedge clk_i);
        #1;
        sync_word = {4'h3, ctrl_pay(1'b0, 1'b0, 1'b1, 1'b0, 6'd5, 6'd1, 16'h0)};
        chk("sync echo", 128'(xbd_o), 128'(sync_word));
        send(4'h3, ctrl_pay(1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 6'd1, 16'h0));
        repeat (2) @(posedge clk_i);
        #1;
        chk("sync cleared", 128'(xbd_o), 128'(0));

        // overrun: address and second trigger during CYCLE are dropped
        chk("ovr before", 128'(ovr_o), 128'(0));
        start_txn(1'b1, 16'h00F0, 6'd1);
        send(4'h1, 32'h9999_9999);
        chk("ovr after adr", 128'(ovr_o), 128'(1));
        send(4'h3, ctrl_pay(1'b0, 1'b1, 1'b0, 1'b0, 6'd2, 6'd1, 16'hFFFF));
        chk("ovr sticky", 128'(ovr_o), 128'(1));
        chk("adr kept", 128'(adr_o), 128'(model_adr));
        chk("cyc kept", 128'(cyc_o), 128'(1));
        chk("sel kept", 128'(sel_o), 128'(16'h00F0));
        finish_txn(0, 0, 128'h0);
        expect_words();

        // tx slots withheld during RESP hold the outgoing word
        tx_mode = 2;
        tx_man  = 1'b0;
        start_txn(1'b0, 16'hFFFF, 6'd7);
        finish_txn(0, 0, {32'h0D0D_0D0D, 32'h0C0C_0C0C, 32'h0B0B_0B0B, 32'h0A0A_0A0A});
        repeat (3) @(posedge clk_i);
        #1;
        chk("no slot no word", 128'(got_q.size()), 128'(0));
        tx_man = 1'b1;
        @(posedge clk_i); #1;
        tx_man = 1'b0;
        @(posedge clk_i); #1;
        chk("one slot one word", 128'(got_q.size()), 128'(1));
        for (int i = 0; i < 5; i++) begin
            @(posedge clk_i); #1;
            chk($sformatf("hold %0d", i), 128'(xbd_o), 128'(exp_q[0]));
        end
        tx_mode = 0;
        expect_words();

        // randomized transactions with random tx slots
        tx_mode = 1;
        for (int it = 0; it < 30; it++) begin
            if ($urandom_range(3, 0) == 0) begin
                send(4'h3, ctrl_pay(1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 6'd2, 16'h0));
                chk("rnd deselect", 128'(sel_flag_o), 128'(0));
                send(4'h1, $urandom);
                send(4'h3, ctrl_pay(1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 6'd1, 16'h0));
                chk("rnd reselect", 128'(sel_flag_o), 128'(1));
            end
            if ($urandom_range(1, 0) == 1) begin
                a = $urandom;
                load_adr(a);
            end
            for (int n = 0; n < 4; n++)
                if ($urandom_range(1, 0) == 1) load_dat(n, $urandom);
            we = 1'($urandom_range(1, 0));
            case ($urandom_range(4, 0))
                0:       sel = 16'hFFFF;
                1:       sel = 16'h0000;
                2:       sel = 16'h0F00;
                3:       sel = 16'h1002;
                default: sel = 16'($urandom);
            endcase
            rd = {$urandom, $urandom, $urandom, $urandom};
            start_txn(we, sel, 6'($urandom));
            finish_txn(($urandom_range(6, 0) == 0) ? 1 : 0, $urandom_range(4, 0), rd);
            expect_words();
        end
        tx_mode = 0;

        // asynchronous reset in the middle of a bus cycle
        start_txn(1'b0, 16'hFFFF, 6'd1);
        #1;
        rst_ni = 1'b0;
        #1;
        chk_reset_outputs("mid reset");
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        got_q.delete();
        repeat (10) @(posedge clk_i);
        #1;
        chk("no completion after reset", 128'(got_q.size()), 128'(0));
        chk("cyc stays low", 128'(cyc_o), 128'(0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
